// File: rtl/cluster_unpacker.sv
// -----------------------------------------------------------------------------
// cluster_unpacker
//
// Rebuilds one bunch crossing's pad hit map from a packed cluster list. This is
// the inverse of the 8-cluster finder. It is used for loopback checking,
// emulation and DAQ-side reconstruction.
//
// A list of up to 8 clusters is captured on `load`. Each cluster is an 11-bit
// start pad plus a 3-bit count, and its size is count+1 pads. The block then
// expands one slot per clock into a working map. After slot 7 it publishes the
// map, the number of in-range clusters and an overlap flag.
//
// Timing: load sampled at edge N, slots expanded at edges N+1..N+8, outputs and
// the valid pulse updated at edge N+9. busy covers cycles N+1..N+9.
//
// Ports
//   clock4x       in   160 MHz clock, all logic on the rising edge
//   global_reset  in   synchronous, active-high reset
//   load          in   capture adr0..adr7 / cnt0..cnt7 this cycle
//   adr0..adr7    in   cluster start pad; a value >= MXPADS marks an empty slot
//   cnt0..cnt7    in   cluster size minus one
//   busy          out  expansion in progress; loads are dropped while high
//   valid         out  one-cycle pulse: vpfs_out / n_clusters / overlap updated
//   vpfs_out      out  reconstructed hit map, bit i = pad i
//   n_clusters    out  in-range clusters in the last published list (0..8)
//   overlap       out  some pad of the last published list was hit twice
//   load_dropped  out  one-cycle pulse: a load arrived while busy
// -----------------------------------------------------------------------------
module cluster_unpacker #(
    parameter int MXPADS     = 1536,
    parameter int MXADRBITS  = 11,
    parameter int MXCNTBITS  = 3,
    parameter int MXCLUSTERS = 8
) (
    input  logic                 clock4x,
    input  logic                 global_reset,
    input  logic                 load,
    input  logic [MXADRBITS-1:0] adr0,
    input  logic [MXADRBITS-1:0] adr1,
    input  logic [MXADRBITS-1:0] adr2,
    input  logic [MXADRBITS-1:0] adr3,
    input  logic [MXADRBITS-1:0] adr4,
    input  logic [MXADRBITS-1:0] adr5,
    input  logic [MXADRBITS-1:0] adr6,
    input  logic [MXADRBITS-1:0] adr7,
    input  logic [MXCNTBITS-1:0] cnt0,
    input  logic [MXCNTBITS-1:0] cnt1,
    input  logic [MXCNTBITS-1:0] cnt2,
    input  logic [MXCNTBITS-1:0] cnt3,
    input  logic [MXCNTBITS-1:0] cnt4,
    input  logic [MXCNTBITS-1:0] cnt5,
    input  logic [MXCNTBITS-1:0] cnt6,
    input  logic [MXCNTBITS-1:0] cnt7,
    output logic                 busy,
    output logic                 valid,
    output logic [MXPADS-1:0]    vpfs_out,
    output logic [3:0]           n_clusters,
    output logic                 overlap,
    output logic                 load_dropped
);

    // Longest cluster in pads: a full-scale count plus one.
    localparam int RUNW = 1 << MXCNTBITS;
    localparam logic [MXADRBITS-1:0] PAD_LIMIT = MXADRBITS'(MXPADS);
    localparam logic [2:0] LAST_SLOT = 3'(MXCLUSTERS - 1);

    // FSM encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXPAND  = 2'd1;
    localparam logic [1:0] PUBLISH = 2'd2;

    logic [1:0]           state;
    logic [2:0]           slot_idx;
    logic [3:0]           tally;
    logic                 overlap_work;
    logic [MXPADS-1:0]    work_map;

    logic [MXADRBITS-1:0] adr_in   [MXCLUSTERS];
    logic [MXCNTBITS-1:0] cnt_in   [MXCLUSTERS];
    logic [MXADRBITS-1:0] list_adr [MXCLUSTERS];
    logic [MXCNTBITS-1:0] list_cnt [MXCLUSTERS];

    logic [MXADRBITS-1:0] slot_adr;
    logic [MXCNTBITS-1:0] slot_cnt;
    logic                 slot_in_range;
    logic [RUNW:0]        run_ext;
    logic [RUNW-1:0]      run;
    logic [MXPADS+RUNW-1:0] run_wide;
    logic [MXPADS-1:0]    slot_mask;
    logic                 slot_hit;

    // Gather the flat slot ports into arrays so the slot mux is a simple index.
    assign adr_in[0] = adr0;
    assign adr_in[1] = adr1;
    assign adr_in[2] = adr2;
    assign adr_in[3] = adr3;
    assign adr_in[4] = adr4;
    assign adr_in[5] = adr5;
    assign adr_in[6] = adr6;
    assign adr_in[7] = adr7;
    assign cnt_in[0] = cnt0;
    assign cnt_in[1] = cnt1;
    assign cnt_in[2] = cnt2;
    assign cnt_in[3] = cnt3;
    assign cnt_in[4] = cnt4;
    assign cnt_in[5] = cnt5;
    assign cnt_in[6] = cnt6;
    assign cnt_in[7] = cnt7;

    // -------------------------------------------------------------------------
    // Expansion datapath for the current slot
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        slot_adr      = list_adr[slot_idx];
        slot_cnt      = list_cnt[slot_idx];
        slot_in_range = (slot_adr < PAD_LIMIT);

        // cnt+1 contiguous ones at the bottom of a RUNW-bit field.
        run_ext = ((RUNW+1)'(2) << slot_cnt) - (RUNW+1)'(1);
        run     = run_ext[RUNW-1:0];

        // Shift the run into place in a field RUNW bits wider than the map.
        // Keeping only the low MXPADS bits clips pads beyond the last one
        // instead of wrapping them back to pad 0.
        run_wide  = {{MXPADS{1'b0}}, run} << slot_adr;
        slot_mask = slot_in_range ? run_wide[MXPADS-1:0] : '0;
        slot_hit  = |(slot_mask & work_map);
    end

    // -------------------------------------------------------------------------
    // Captured list and working map
    // -------------------------------------------------------------------------
    always_ff @(posedge clock4x) begin
        // NOTE: sequential state is written with non-blocking assignments only,
        // so every register samples the pre-edge values regardless of order.
        if (global_reset) begin
            // NOTE: the working map and the list are flops, not a RAM. Clearing
            // them on reset means a list aborted by reset never leaks into a
            // later publish.
            work_map <= '0;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                list_adr[i] <= '0;
                list_cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        work_map <= '0;
                        for (int i = 0; i < MXCLUSTERS; i++) begin
                            list_adr[i] <= adr_in[i];
                            list_cnt[i] <= cnt_in[i];
                        end
                    end
                end
                EXPAND: begin
                    work_map <= work_map | slot_mask;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and published outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            state        <= IDLE;
            slot_idx     <= '0;
            tally        <= '0;
            overlap_work <= 1'b0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            vpfs_out     <= '0;
            n_clusters   <= '0;
            overlap      <= 1'b0;
            load_dropped <= 1'b0;
        end else begin
            valid        <= 1'b0;
            // busy is high in every non-IDLE state, including the PUBLISH edge,
            // so a load that coincides with publishing is also dropped.
            load_dropped <= load && busy;

            case (state)
                IDLE: begin
                    if (load) begin
                        slot_idx     <= '0;
                        tally        <= '0;
                        overlap_work <= 1'b0;
                        busy         <= 1'b1;
                        state        <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (slot_hit) begin
                        overlap_work <= 1'b1;
                    end
                    if (slot_in_range) begin
                        tally <= tally + 4'd1;
                    end
                    slot_idx <= slot_idx + 3'd1;
                    // All slots are always visited, so the latency is fixed.
                    if (slot_idx == LAST_SLOT) begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    vpfs_out   <= work_map;
                    n_clusters <= tally;
                    overlap    <= overlap_work;
                    valid      <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cluster_unpacker.sv
// -----------------------------------------------------------------------------
// tb_cluster_unpacker
//
// Table-driven bench for cluster_unpacker. Each record holds one cluster list,
// the expected hit map as a list of hand-computed pad ranges, the expected
// cluster count and the expected overlap flag. Hand-written sequences cover
// these cases:
//   - a load while busy, and a load on the publish edge
//   - back-to-back loads
//   - reset in the middle of an expansion
// Inputs are driven on the falling edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_cluster_unpacker;

    localparam int MXPADS = 1536;
    localparam int NVEC   = 6;

    logic              clock4x = 1'b0;
    logic              global_reset = 1'b1;
    logic              load = 1'b0;
    logic [10:0]       adr [8];
    logic [2:0]        cnt [8];
    logic              busy;
    logic              valid;
    logic [MXPADS-1:0] vpfs_out;
    logic [3:0]        n_clusters;
    logic              overlap;
    logic              load_dropped;

    always #3 clock4x = ~clock4x;

    cluster_unpacker dut (
        .clock4x      (clock4x),
        .global_reset (global_reset),
        .load         (load),
        .adr0         (adr[0]),
        .adr1         (adr[1]),
        .adr2         (adr[2]),
        .adr3         (adr[3]),
        .adr4         (adr[4]),
        .adr5         (adr[5]),
        .adr6         (adr[6]),
        .adr7         (adr[7]),
        .cnt0         (cnt[0]),
        .cnt1         (cnt[1]),
        .cnt2         (cnt[2]),
        .cnt3         (cnt[3]),
        .cnt4         (cnt[4]),
        .cnt5         (cnt[5]),
        .cnt6         (cnt[6]),
        .cnt7         (cnt[7]),
        .busy         (busy),
        .valid        (valid),
        .vpfs_out     (vpfs_out),
        .n_clusters   (n_clusters),
        .overlap      (overlap),
        .load_dropped (load_dropped)
    );

    // Inputs, then the expected result as up to 8 inclusive pad ranges.
    typedef struct packed {
        logic [7:0][10:0] adr;
        logic [7:0][2:0]  cnt;
        logic [3:0]       nr;
        logic [7:0][10:0] lo;
        logic [7:0][10:0] hi;
        logic [3:0]       n;
        logic             ovl;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_map(input string name, input logic [MXPADS-1:0] exp);
        int first;
        n_vec++;
        if (vpfs_out !== exp) begin
            n_bad++;
            first = -1;
            for (int i = 0; i < MXPADS; i++) begin
                if (first < 0 && vpfs_out[i] !== exp[i]) first = i;
            end
            $display("FAIL %s: map differs first at pad %0d (got %b, expected %b); popcount got %0d, expected %0d",
                     name, first, vpfs_out[first], exp[first], $countones(vpfs_out), $countones(exp));
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '0;
        for (int i = 0; i < 8; i++) v.adr[i] = 11'h7FF;
        return v;
    endfunction

    function automatic logic [MXPADS-1:0] build_map(input vec_t v);
        logic [MXPADS-1:0] m;
        m = '0;
        for (int r = 0; r < 8; r++) begin
            if (r < int'(v.nr)) begin
                for (int p = int'(v.lo[r]); p <= int'(v.hi[r]); p++) m[p] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic drive_list(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            adr[i] = v.adr[i];
            cnt[i] = v.cnt[i];
        end
    endtask

    task automatic tick();
        @(posedge clock4x);
        @(negedge clock4x);
    endtask

    // Load one list, wait (bounded) for valid, then check latency and results.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clock4x);
        drive_list(v);
        load = 1'b1;
        tick();
        load = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        lat = 0;
        while (!valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_end"}, busy, 0);
        check_map({tag, "_map"}, build_map(v));
        check({tag, "_n_clusters"}, n_clusters, v.n);
        check({tag, "_overlap"}, overlap, v.ovl);
        tick();
        check({tag, "_valid_pulse"}, valid, 0);
    endtask

    initial begin
        vec_t a;
        vec_t b;
        vec_t c;
        int   vcount;

        // ---- stimulus table ----
        // 0: single cluster, pads 10..12
        vecs[0] = blank();
        vecs[0].adr[0] = 11'd10;  vecs[0].cnt[0] = 3'd2;
        vecs[0].nr = 4'd1; vecs[0].lo[0] = 11'd10; vecs[0].hi[0] = 11'd12;
        vecs[0].n = 4'd1; vecs[0].ovl = 1'b0;
        // 1: full list across both halves, 1535+7 clipped to a single pad
        vecs[1] = blank();
        vecs[1].adr[0] = 11'd0;    vecs[1].cnt[0] = 3'd0;
        vecs[1].adr[1] = 11'd100;  vecs[1].cnt[1] = 3'd7;
        vecs[1].adr[2] = 11'd767;  vecs[1].cnt[2] = 3'd0;
        vecs[1].adr[3] = 11'd768;  vecs[1].cnt[3] = 3'd3;
        vecs[1].adr[4] = 11'd800;  vecs[1].cnt[4] = 3'd1;
        vecs[1].adr[5] = 11'd1000; vecs[1].cnt[5] = 3'd0;
        vecs[1].adr[6] = 11'd1400; vecs[1].cnt[6] = 3'd2;
        vecs[1].adr[7] = 11'd1535; vecs[1].cnt[7] = 3'd7;
        vecs[1].nr = 4'd8;
        vecs[1].lo[0] = 11'd0;    vecs[1].hi[0] = 11'd0;
        vecs[1].lo[1] = 11'd100;  vecs[1].hi[1] = 11'd107;
        vecs[1].lo[2] = 11'd767;  vecs[1].hi[2] = 11'd767;
        vecs[1].lo[3] = 11'd768;  vecs[1].hi[3] = 11'd771;
        vecs[1].lo[4] = 11'd800;  vecs[1].hi[4] = 11'd801;
        vecs[1].lo[5] = 11'd1000; vecs[1].hi[5] = 11'd1000;
        vecs[1].lo[6] = 11'd1400; vecs[1].hi[6] = 11'd1402;
        vecs[1].lo[7] = 11'd1535; vecs[1].hi[7] = 11'd1535;
        vecs[1].n = 4'd8; vecs[1].ovl = 1'b0;
        // 2: overlapping clusters 50..54 and 52..53
        vecs[2] = blank();
        vecs[2].adr[0] = 11'd50; vecs[2].cnt[0] = 3'd4;
        vecs[2].adr[1] = 11'd52; vecs[2].cnt[1] = 3'd1;
        vecs[2].nr = 4'd1; vecs[2].lo[0] = 11'd50; vecs[2].hi[0] = 11'd54;
        vecs[2].n = 4'd2; vecs[2].ovl = 1'b1;
        // 3: clean list right after, adjacent but disjoint: overlap must clear
        vecs[3] = blank();
        vecs[3].adr[0] = 11'd300; vecs[3].cnt[0] = 3'd1;
        vecs[3].adr[1] = 11'd302; vecs[3].cnt[1] = 3'd0;
        vecs[3].nr = 4'd1; vecs[3].lo[0] = 11'd300; vecs[3].hi[0] = 11'd302;
        vecs[3].n = 4'd2; vecs[3].ovl = 1'b0;
        // 4: clipped cluster 1530..1535, adr 1536 skipped, pad 0 in slot 6
        vecs[4] = blank();
        vecs[4].adr[2] = 11'd1530;  vecs[4].cnt[2] = 3'd7;
        vecs[4].adr[3] = 11'h600;   vecs[4].cnt[3] = 3'd7;
        vecs[4].adr[6] = 11'd0;     vecs[4].cnt[6] = 3'd0;
        vecs[4].nr = 4'd2;
        vecs[4].lo[0] = 11'd0;    vecs[4].hi[0] = 11'd0;
        vecs[4].lo[1] = 11'd1530; vecs[4].hi[1] = 11'd1535;
        vecs[4].n = 4'd2; vecs[4].ovl = 1'b0;
        // 5: empty list publishes an empty map
        vecs[5] = blank();
        vecs[5].n = 4'd0; vecs[5].ovl = 1'b0;

        // ---- reset then idle ----
        drive_list(blank());
        repeat (2) @(posedge clock4x);
        @(negedge clock4x);
        global_reset = 1'b0;
        repeat (3) begin
            check_map("rst_map", '0);
            check("rst_n_clusters", n_clusters, 0);
            check("rst_valid", valid, 0);
            check("rst_busy", busy, 0);
            check("rst_overlap", overlap, 0);
            check("rst_load_dropped", load_dropped, 0);
            tick();
        end

        // ---- table ----
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- load while busy, back-to-back load, load on the publish edge ----
        a = vecs[0];
        b = blank();
        b.adr[0] = 11'd200; b.cnt[0] = 3'd3;
        c = vecs[2];
        vcount = 0;
        drive_list(a);
        load = 1'b1;
        tick();                          // edge N captures list a
        load = 1'b0;
        for (int e = 0; e < 10; e++) begin
            // here: just after edge N+e
            if (valid) vcount++;
            if (e == 2) begin
                drive_list(b);
                load = 1'b1;             // sampled at edge N+3
            end else if (e == 3) begin
                check("drop_pulse", load_dropped, 1);
                load = 1'b0;
            end else if (e == 4) begin
                check("drop_pulse_end", load_dropped, 0);
            end
            if (e == 9) begin
                check("drop_busy_end", busy, 0);
                check_map("drop_map_is_first", build_map(a));
                check("drop_n_clusters", n_clusters, 1);
                drive_list(c);
                load = 1'b1;             // sampled at edge N+10
            end
            tick();
        end
        load = 1'b0;
        check("drop_valid_count", vcount, 1);
        check("b2b_accepted_busy", busy, 1);
        check("b2b_no_drop", load_dropped, 0);
        // c was captured at edge M=N+10 and publishes at M+9.
        // Raise load so it is sampled on that publish edge.
        for (int e = 1; e < 9; e++) tick();
        drive_list(a);
        load = 1'b1;
        tick();                          // edge M+9
        load = 1'b0;
        check("b2b_valid", valid, 1);
        check_map("b2b_map", build_map(c));
        check("b2b_overlap", overlap, 1);
        check("publish_edge_drop", load_dropped, 1);
        tick();
        check("publish_edge_not_started", busy, 0);

        // ---- reset in the middle of an expansion ----
        drive_list(vecs[1]);
        load = 1'b1;
        tick();                          // edge N
        load = 1'b0;
        tick();
        tick();
        tick();                          // after edge N+3
        global_reset = 1'b1;             // sampled at edge N+4
        tick();
        global_reset = 1'b0;
        check("midrst_busy", busy, 0);
        check_map("midrst_map", '0);
        check("midrst_n_clusters", n_clusters, 0);
        check("midrst_overlap", overlap, 0);
        vcount = 0;
        for (int e = 0; e < 12; e++) begin
            if (valid) vcount++;
            tick();
        end
        check("midrst_no_valid", vcount, 0);
        check_map("midrst_map_hold", '0);
        run_vec(vecs[1], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
